// File: rtl/decode_cycle.sv
// decode_cycle: RV32I instruction decode stage.
//   Holds the 32-entry register file (x0 hardwired to zero), the immediate
//   generator, the control decoder and the ID/EX pipeline register.
//   Every output is registered and is valid one clock after capture.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   pc_in, instr_in       instruction from fetch; valid_in marks a real one
//   stall, flush          hazard control (flush wins over stall)
//   wb_en, wb_rd, wb_data register file write port from write-back
//   pc_out .. illegal     ID/EX register contents for the execute stage
module decode_cycle #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    pc_in,
  input  logic [WIDTH-1:0]    instr_in,
  input  logic                valid_in,
  input  logic                stall,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [REG_ADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0]    wb_data,
  output logic [WIDTH-1:0]    pc_out,
  output logic [WIDTH-1:0]    rs1_data,
  output logic [WIDTH-1:0]    rs2_data,
  output logic [WIDTH-1:0]    imm,
  output logic [REG_ADDR-1:0] rs1,
  output logic [REG_ADDR-1:0] rs2,
  output logic [REG_ADDR-1:0] rd,
  output logic [3:0]          alu_ctrl,
  output logic                alu_src_imm,
  output logic                alu_src_pc,
  output logic [1:0]          result_src,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic                jalr,
  output logic [2:0]          funct3,
  output logic                valid_out,
  output logic                illegal
);

  localparam int unsigned NREGS = 1 << REG_ADDR;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_e;

  typedef struct packed {
    logic                valid;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    rs1_data;
    logic [WIDTH-1:0]    rs2_data;
    logic [WIDTH-1:0]    imm;
    logic [REG_ADDR-1:0] rs1;
    logic [REG_ADDR-1:0] rs2;
    logic [REG_ADDR-1:0] rd;
    alu_e                alu_ctrl;
    logic                alu_src_imm;
    logic                alu_src_pc;
    logic [1:0]          result_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic                jalr;
    logic [2:0]          funct3;
    logic                illegal;
  } idex_t;

  // funct3 -> ALU operation for the funct7 = 0 encodings of OP / OP-IMM
  function automatic alu_e alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [WIDTH-1:0]    rf_q [NREGS];
  idex_t               idex_q, idex_d, dec;
  logic                legal;

  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [REG_ADDR-1:0] rs1_idx, rs2_idx;
  logic [WIDTH-1:0]    rs1_val, rs2_val;
  logic [WIDTH-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = instr_in[6:0];
  assign f3      = instr_in[14:12];
  assign f7      = instr_in[31:25];
  assign rs1_idx = instr_in[15 +: REG_ADDR];
  assign rs2_idx = instr_in[20 +: REG_ADDR];

  assign imm_i = {{(WIDTH-11){instr_in[31]}}, instr_in[30:20]};
  assign imm_s = {{(WIDTH-11){instr_in[31]}}, instr_in[30:25], instr_in[11:7]};
  assign imm_b = {{(WIDTH-12){instr_in[31]}}, instr_in[7], instr_in[30:25],
                  instr_in[11:8], 1'b0};
  assign imm_u = {{(WIDTH-31){instr_in[31]}}, instr_in[30:12], 12'b0};
  assign imm_j = {{(WIDTH-20){instr_in[31]}}, instr_in[19:12], instr_in[20],
                  instr_in[30:21], 1'b0};

  // Write-through: a same-cycle write-back to the source register is seen here
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != '0)
      rs1_val = (wb_en && wb_rd == rs1_idx) ? wb_data : rf_q[rs1_idx];
    if (rs2_idx != '0)
      rs2_val = (wb_en && wb_rd == rs2_idx) ? wb_data : rf_q[rs2_idx];
  end

  always_comb begin
    legal        = 1'b0;
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = pc_in;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = instr_in[7 +: REG_ADDR];
    dec.funct3   = f3;
    dec.rs1_data = rs1_val;
    dec.rs2_data = rs2_val;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; dec.imm = imm_u; dec.alu_ctrl = ALU_PASSB;
        dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; dec.imm = imm_u; dec.alu_ctrl = ALU_ADD;
        dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; dec.imm = imm_j; dec.alu_ctrl = ALU_ADD;
        dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1; dec.reg_write = 1'b1;
        dec.jump = 1'b1; dec.result_src = 2'd2;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); dec.imm = imm_i; dec.alu_ctrl = ALU_ADD;
        dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.jump = 1'b1; dec.jalr = 1'b1; dec.result_src = 2'd2;
      end
      OPC_BRANCH: begin
        legal = !(f3 inside {3'b010, 3'b011}); dec.imm = imm_b;
        dec.alu_ctrl = ALU_SUB; dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.imm = imm_i; dec.alu_ctrl = ALU_ADD; dec.alu_src_imm = 1'b1;
        dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'd1;
      end
      OPC_STORE: begin
        legal = (f3 <= 3'b010); dec.imm = imm_s; dec.alu_ctrl = ALU_ADD;
        dec.alu_src_imm = 1'b1; dec.mem_write = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        case (f3)
          3'b001: begin legal = (f7 == 7'h00); dec.alu_ctrl = ALU_SLL; end
          3'b101: begin
            legal = (f7 == 7'h00) || (f7 == 7'h20);
            dec.alu_ctrl = f7[5] ? ALU_SRA : ALU_SRL;
          end
          // immediate arithmetic: upper bits are immediate, ADDI never subtracts
          default: begin legal = 1'b1; dec.alu_ctrl = alu_base(f3); end
        endcase
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'h00) begin
          legal = 1'b1; dec.alu_ctrl = alu_base(f3);
        end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal = 1'b1; dec.alu_ctrl = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings still travel down the pipe (valid) but must do nothing
    if (!legal) begin
      dec.imm         = '0;
      dec.alu_ctrl    = ALU_ADD;
      dec.alu_src_imm = 1'b0;
      dec.alu_src_pc  = 1'b0;
      dec.result_src  = 2'd0;
      dec.reg_write   = 1'b0;
      dec.mem_read    = 1'b0;
      dec.mem_write   = 1'b0;
      dec.branch      = 1'b0;
      dec.jump        = 1'b0;
      dec.jalr        = 1'b0;
      dec.illegal     = 1'b1;
    end

    // S/B formats reuse the rd field for immediate bits
    if (opcode == OPC_STORE || opcode == OPC_BRANCH)
      dec.rd = '0;
  end

  always_comb begin
    idex_d = '0;
    if (flush)         idex_d = '0;
    else if (stall)    idex_d = idex_q;
    else if (valid_in) idex_d = dec;
  end

  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rf_q <= '{default: '0};
    else if (wb_en && wb_rd != '0)
      rf_q[wb_rd] <= wb_data;
  end

  assign pc_out      = idex_q.pc;
  assign rs1_data    = idex_q.rs1_data;
  assign rs2_data    = idex_q.rs2_data;
  assign imm         = idex_q.imm;
  assign rs1         = idex_q.rs1;
  assign rs2         = idex_q.rs2;
  assign rd          = idex_q.rd;
  assign alu_ctrl    = idex_q.alu_ctrl;
  assign alu_src_imm = idex_q.alu_src_imm;
  assign alu_src_pc  = idex_q.alu_src_pc;
  assign result_src  = idex_q.result_src;
  assign reg_write   = idex_q.reg_write;
  assign mem_read    = idex_q.mem_read;
  assign mem_write   = idex_q.mem_write;
  assign branch      = idex_q.branch;
  assign jump        = idex_q.jump;
  assign jalr        = idex_q.jalr;
  assign funct3      = idex_q.funct3;
  assign valid_out   = idex_q.valid;
  assign illegal     = idex_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed cases with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        reset, valid_in, stall, flush, wb_en;
  logic [31:0] pc_in, instr_in, wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] pc_out, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_ctrl;
  logic        alu_src_imm, alu_src_pc;
  logic [1:0]  result_src;
  logic        reg_write, mem_read, mem_write, branch, jump, jalr;
  logic [2:0]  funct3;
  logic        valid_out, illegal;

  always #5 clk = ~clk;

  decode_cycle #(.WIDTH(32), .REG_ADDR(5)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .valid_in(valid_in), .stall(stall), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .pc_out(pc_out), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc),
    .result_src(result_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .jalr(jalr),
    .funct3(funct3), .valid_out(valid_out), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        src_imm, src_pc;
    logic [1:0]  res;
    logic        rw, mr, mw, br, jp, jr;
    logic [2:0]  f3;
    logic        valid, ill;
  } exp_t;

  exp_t        m_exp;
  logic [31:0] m_rf [32];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic exp_t act_vec();
    exp_t a;
    a.pc = pc_out; a.d1 = rs1_data; a.d2 = rs2_data; a.imm = imm;
    a.rs1 = rs1; a.rs2 = rs2; a.rd = rd; a.alu = alu_ctrl;
    a.src_imm = alu_src_imm; a.src_pc = alu_src_pc; a.res = result_src;
    a.rw = reg_write; a.mr = mem_read; a.mw = mem_write; a.br = branch;
    a.jp = jump; a.jr = jalr; a.f3 = funct3; a.valid = valid_out; a.ill = illegal;
    return a;
  endfunction

  // Behavioural decode: immediates by arithmetic shifting, ALU code from a
  // funct3 lookup table with the funct7[5] variant as the next code up.
  function automatic exp_t model_decode(logic [31:0] pc, logic [31:0] ins,
                                        logic [31:0] v1, logic [31:0] v2);
    exp_t        e;
    logic [3:0]  tab [8];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    bit          ok;
    tab   = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc   = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    i_imm = $signed(ins) >>> 20;
    s_imm = (i_imm & ~32'd31) | 32'(ins[11:7]);
    u_imm = ins & 32'hFFFF_F000;
    b_imm = (s_imm & ~32'h801) | (32'(ins[7]) << 11);
    j_imm = (i_imm & 32'hFFF0_07FE) | (ins & 32'h000F_F000) | (32'(ins[20]) << 11);
    e = '0; ok = 0;
    e.valid = 1; e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.rd = ins[11:7]; e.f3 = f3; e.d1 = v1; e.d2 = v2;
    if (opc == 7'h37) begin
      ok = 1; e.imm = u_imm; e.alu = 10; e.src_imm = 1; e.rw = 1;
    end else if (opc == 7'h17) begin
      ok = 1; e.imm = u_imm; e.src_imm = 1; e.src_pc = 1; e.rw = 1;
    end else if (opc == 7'h6F) begin
      ok = 1; e.imm = j_imm; e.src_imm = 1; e.src_pc = 1; e.rw = 1; e.jp = 1; e.res = 2;
    end else if (opc == 7'h67) begin
      ok = (f3 == 0); e.imm = i_imm; e.src_imm = 1; e.rw = 1; e.jp = 1; e.jr = 1; e.res = 2;
    end else if (opc == 7'h63) begin
      ok = (f3 != 2 && f3 != 3); e.imm = b_imm; e.alu = 1; e.br = 1;
    end else if (opc == 7'h03) begin
      ok = (f3 != 3 && f3 < 6); e.imm = i_imm; e.src_imm = 1; e.mr = 1; e.rw = 1; e.res = 1;
    end else if (opc == 7'h23) begin
      ok = (f3 < 3); e.imm = s_imm; e.src_imm = 1; e.mw = 1;
    end else if (opc == 7'h13) begin
      ok = (f3 != 1 && f3 != 5) || f7 == 0 || (f3 == 5 && f7 == 7'h20);
      e.imm = i_imm; e.src_imm = 1; e.rw = 1;
      e.alu = tab[f3] + ((f3 == 5 && f7[5]) ? 4'd1 : 4'd0);
    end else if (opc == 7'h33) begin
      ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      e.rw = 1; e.alu = tab[f3] + (f7[5] ? 4'd1 : 4'd0);
    end
    if (!ok) begin
      e.imm = 0; e.alu = 0; e.src_imm = 0; e.src_pc = 0; e.res = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.jr = 0; e.ill = 1;
    end
    if (opc == 7'h23 || opc == 7'h63) e.rd = 0;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_vec(string name, exp_t act, exp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: drive, advance the model, then compare every output.
  task automatic step(input logic rst, input logic v, input logic st,
                      input logic fl, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [31:0] pcv,
                      input logic [31:0] ins);
    logic [31:0] after [32];
    logic [31:0] v1, v2;
    reset = rst; valid_in = v; stall = st; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd; pc_in = pcv; instr_in = ins;
    // register values as they stand once this cycle's write-back lands
    after = m_rf;
    if (we && wr != 0) after[wr] = wd;
    v1 = (ins[19:15] == 0) ? 32'd0 : after[ins[19:15]];
    v2 = (ins[24:20] == 0) ? 32'd0 : after[ins[24:20]];
    if (rst) begin
      m_exp = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (fl)      m_exp = '0;
      else if (!st) m_exp = v ? model_decode(pcv, ins, v1, v2) : '0;
      m_rf = after;
    end
    @(posedge clk);
    #1;
    check_vec("idex_model", act_vec(), m_exp);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0]  opcs [9];
    logic [31:0] ins;
    int unsigned k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    ins = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) begin
      ins[6:0] = opcs[k];
      if ((k == 8 || k == 7) && $urandom_range(0, 1) == 1) ins[31:25] = 7'h00;
    end else if (k == 9) begin
      ins[6:0] = 7'h33; ins[31:25] = 7'h20;
    end else if (k == 10) begin
      ins[6:0] = 7'h13; ins[14:12] = 3'b101; ins[31:25] = 7'h20;
    end
    return ins;
  endfunction

  initial begin
    m_exp = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 5, 32'h55, 32'h40, 32'h00500093);
    check_vec("reset_all_zero", act_vec(), '0);

    // addi x1,x0,5
    step(0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h00500093);
    check("addi_rd", rd, 1);
    check("addi_imm", imm, 5);
    check("addi_alu", alu_ctrl, 0);
    check("addi_src_imm", alu_src_imm, 1);
    check("addi_reg_write", reg_write, 1);
    check("addi_valid", valid_out, 1);

    // write-through bypass
    step(0, 1, 0, 0, 1, 2, 32'hDEADBEEF, 32'h104, 32'h002101B3);
    check("bypass_rs1", rs1_data, 32'hDEADBEEF);
    check("bypass_rs2", rs2_data, 32'hDEADBEEF);

    // x0 is never written nor bypassed
    step(0, 1, 0, 0, 1, 0, 32'hFFFFFFFF, 32'h108, 32'h000001B3);
    check("x0_rs1", rs1_data, 0);
    check("x0_rs2", rs2_data, 0);

    // beq x0,x0,-4
    step(0, 1, 0, 0, 0, 0, 0, 32'h10C, 32'hFE000EE3);
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_branch", branch, 1);
    check("beq_alu", alu_ctrl, 1);
    check("beq_reg_write", reg_write, 0);
    check("beq_rd", rd, 0);

    // stall holds for three cycles while the input changes
    step(0, 1, 0, 0, 0, 0, 0, 32'h200, 32'h00500093);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 0, 0, 32'h204 + 32'(4 * i), gen_instr());
      check("stall_pc", pc_out, 32'h200);
      check("stall_imm", imm, 5);
    end

    // flush wins over stall
    step(0, 1, 1, 1, 0, 0, 0, 32'h300, 32'h00500093);
    check("flush_valid", valid_out, 0);
    check("flush_enables", {reg_write, mem_read, mem_write, branch, jump, jalr, illegal}, 0);

    // unsupported opcode
    step(0, 1, 0, 0, 0, 0, 0, 32'h304, 32'hFFFFFFFF);
    check("ill_illegal", illegal, 1);
    check("ill_valid", valid_out, 1);
    check("ill_reg_write", reg_write, 0);
    check("ill_mem_write", mem_write, 0);

    // reset with an instruction in flight, then x1 reads back as zero
    step(0, 1, 0, 0, 1, 1, 32'h1234, 32'h308, 32'h00500093);
    check("pre_reset_valid", valid_out, 1);
    step(1, 1, 0, 0, 0, 0, 0, 32'h30C, 32'h00500093);
    check_vec("mid_reset_zero", act_vec(), '0);
    step(0, 1, 0, 0, 0, 0, 0, 32'h310, 32'h001081B3);
    check("post_reset_x1", rs1_data, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [4:0]  wr;
      ins = gen_instr();
      case ($urandom_range(0, 2))
        0:       wr = ins[19:15];
        1:       wr = ins[24:20];
        default: wr = 5'($urandom);
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 60, wr, $urandom, $urandom & 32'hFFFF_FFFC, ins);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
